// File: rtl/vc_input_unit_if.sv
// Handshake and data bundle of the multi-VC router input unit.
// slave is the input unit side; master is the router/allocator side.
interface vc_input_unit_if #(
    parameter int D_WIDTH   = 32,
    parameter int NUM_VCS   = 4,
    parameter int VID_BITS  = 2,
    parameter int DEST_BITS = 4,
    parameter int CNT_BITS  = 4
);
    logic                        in_valid;
    logic [D_WIDTH-1:0]          in_flit;
    logic [NUM_VCS-1:0]          rc_req, rc_gnt, vc_req, vc_gnt, sa_req, sa_gnt;
    logic [DEST_BITS-1:0]        rc_route, out_route;
    logic [VID_BITS-1:0]         vc_ovid, out_ovid, credit_vc;
    logic                        out_valid, credit_valid, err_overflow, err_protocol;
    logic [D_WIDTH-1:0]          out_flit;
    logic [NUM_VCS*CNT_BITS-1:0] vc_count;

    modport master (
        output in_valid, in_flit, rc_gnt, rc_route, vc_gnt, vc_ovid, sa_gnt,
        input  rc_req, vc_req, sa_req, out_valid, out_flit, out_route, out_ovid,
               credit_valid, credit_vc, vc_count, err_overflow, err_protocol
    );

    modport slave (
        input  in_valid, in_flit, rc_gnt, rc_route, vc_gnt, vc_ovid, sa_gnt,
        output rc_req, vc_req, sa_req, out_valid, out_flit, out_route, out_ovid,
               credit_valid, credit_vc, vc_count, err_overflow, err_protocol
    );
endinterface

// File: rtl/vc_input_unit.sv
// Multi-VC router input unit: per-VC FIFO + RC/VA/SA bid FSM, switch mux, credit return.
// Define VC_SINGLE_FLIT_EN to accept type 00 as a head+tail flit; otherwise it is illegal.
module vc_input_lane #(
    parameter int D_WIDTH   = 32,
    parameter int VC_DEPTH  = 8,
    parameter int VID_BITS  = 2,
    parameter int DEST_BITS = 4,
    parameter int CNT_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [D_WIDTH-1:0]   wr_flit,
    input  logic                 rc_gnt,
    input  logic [DEST_BITS-1:0] rc_route,
    input  logic                 vc_gnt,
    input  logic [VID_BITS-1:0]  vc_ovid,
    input  logic                 sa_gnt,
    output logic                 rc_req,
    output logic                 vc_req,
    output logic                 sa_req,
    output logic                 bad_pop,
    output logic                 ovf,
    output logic [D_WIDTH-1:0]   front,
    output logic [DEST_BITS-1:0] route,
    output logic [VID_BITS-1:0]  ovid,
    output logic [CNT_BITS-1:0]  count
);
    localparam int PTR_W = $clog2(VC_DEPTH);

    typedef enum logic [1:0] {RC_BID, VC_BID, SA_BID} bid_state_e;

    bid_state_e         state, state_nxt;
    logic [D_WIDTH-1:0] mem [VC_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [1:0]         ftype;
    logic               empty, full, is_head, is_tail, sa_pop, pop, wr_ok;

    assign front = mem[rd_ptr];
    assign ftype = front[D_WIDTH-1 -: 2];
    assign empty = (count == '0);
    assign full  = (count == CNT_BITS'(VC_DEPTH));
`ifdef VC_SINGLE_FLIT_EN
    assign is_head = (ftype == 2'b11) || (ftype == 2'b00);
    assign is_tail = (ftype == 2'b01) || (ftype == 2'b00);
`else
    assign is_head = (ftype == 2'b11);
    assign is_tail = (ftype == 2'b01);
`endif

    // A non-head at the front in RC_BID is discarded rather than routed.
    assign rc_req  = !empty && (state == RC_BID) && is_head;
    assign bad_pop = !empty && (state == RC_BID) && !is_head;
    assign vc_req  = !empty && (state == VC_BID);
    assign sa_req  = !empty && (state == SA_BID);
    assign sa_pop  = sa_req && sa_gnt;
    assign pop     = sa_pop || bad_pop;
    assign wr_ok   = wr_en && (!full || pop);
    assign ovf     = wr_en && full && !pop;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RC_BID:  if (rc_req && rc_gnt) state_nxt = VC_BID;
            VC_BID:  if (vc_req && vc_gnt) state_nxt = SA_BID;
            SA_BID:  if (sa_pop && is_tail) state_nxt = RC_BID;
            default: state_nxt = RC_BID;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RC_BID;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            route  <= '0;
            ovid   <= '0;
        end else begin
            state <= state_nxt;
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_ok && !pop) count <= count + CNT_BITS'(1);
            else if (pop && !wr_ok) count <= count - CNT_BITS'(1);
            if (rc_req && rc_gnt) route <= rc_route;
            if (vc_req && vc_gnt) ovid <= vc_ovid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_flit;
    end
endmodule

module vc_input_unit #(
    parameter int D_WIDTH   = 32,
    parameter int NUM_VCS   = 4,
    parameter int VC_DEPTH  = 8,
    parameter int VID_BITS  = 2,
    parameter int DEST_BITS = 4,
    parameter int CNT_BITS  = 4
) (
    input logic          clk,
    input logic          rst,
    vc_input_unit_if.slave bus
);
    logic [VID_BITS-1:0]                  in_vid;
    logic                                 vid_ok, type_ok, in_legal;
    logic [NUM_VCS-1:0]                   rc_req, vc_req, sa_req, rc_eff, vc_eff, sa_eff;
    logic [NUM_VCS-1:0]                   wr_en, bad_pop, ovf;
    logic [NUM_VCS-1:0][D_WIDTH-1:0]      front;
    logic [NUM_VCS-1:0][DEST_BITS-1:0]    route;
    logic [NUM_VCS-1:0][VID_BITS-1:0]     ovid;
    logic [NUM_VCS-1:0][CNT_BITS-1:0]     count;
    logic [D_WIDTH-1:0]                   flit_mux;
    logic [DEST_BITS-1:0]                 route_mux;
    logic [VID_BITS-1:0]                  ovid_mux, pop_vc;
    logic                                 credit_valid_q, err_ovf_q, err_proto_q;
    logic [VID_BITS-1:0]                  credit_vc_q;

    function automatic logic [NUM_VCS-1:0] lowest(input logic [NUM_VCS-1:0] x);
        return x & (~x + NUM_VCS'(1));
    endfunction

    assign in_vid = bus.in_flit[D_WIDTH-3 -: VID_BITS];
    assign vid_ok = {1'b0, in_vid} < (VID_BITS+1)'(NUM_VCS);
`ifdef VC_SINGLE_FLIT_EN
    assign type_ok = 1'b1;
`else
    assign type_ok = (bus.in_flit[D_WIDTH-1 -: 2] != 2'b00);
`endif
    assign in_legal = bus.in_valid && vid_ok && type_ok;

    // Grants are qualified by requests before picking the lowest bit, so
    // out_valid is exactly |(sa_gnt & sa_req).
    assign rc_eff = lowest(bus.rc_gnt & rc_req);
    assign vc_eff = lowest(bus.vc_gnt & vc_req);
    assign sa_eff = lowest(bus.sa_gnt & sa_req);

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_lane
        assign wr_en[v] = in_legal && (in_vid == VID_BITS'(v));

        vc_input_lane #(
            .D_WIDTH(D_WIDTH), .VC_DEPTH(VC_DEPTH), .VID_BITS(VID_BITS),
            .DEST_BITS(DEST_BITS), .CNT_BITS(CNT_BITS)
        ) u_lane (
            .clk(clk), .rst(rst),
            .wr_en(wr_en[v]), .wr_flit(bus.in_flit),
            .rc_gnt(rc_eff[v]), .rc_route(bus.rc_route),
            .vc_gnt(vc_eff[v]), .vc_ovid(bus.vc_ovid),
            .sa_gnt(sa_eff[v]),
            .rc_req(rc_req[v]), .vc_req(vc_req[v]), .sa_req(sa_req[v]),
            .bad_pop(bad_pop[v]), .ovf(ovf[v]),
            .front(front[v]), .route(route[v]), .ovid(ovid[v]), .count(count[v])
        );
    end

    always_comb begin
        flit_mux  = '0;
        route_mux = '0;
        ovid_mux  = '0;
        pop_vc    = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (sa_eff[v]) begin
                flit_mux  = front[v];
                route_mux = route[v];
                ovid_mux  = ovid[v];
                pop_vc    = VID_BITS'(v);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            err_ovf_q      <= 1'b0;
            err_proto_q    <= 1'b0;
        end else begin
            credit_valid_q <= |sa_eff;
            credit_vc_q    <= pop_vc;
            err_ovf_q      <= err_ovf_q | (|ovf);
            err_proto_q    <= err_proto_q | (bus.in_valid && !(vid_ok && type_ok)) | (|bad_pop);
        end
    end

    assign bus.rc_req       = rc_req;
    assign bus.vc_req       = vc_req;
    assign bus.sa_req       = sa_req;
    assign bus.out_valid    = |sa_eff;
    assign bus.out_flit     = flit_mux;
    assign bus.out_route    = route_mux;
    assign bus.out_ovid     = ovid_mux;
    assign bus.credit_valid = credit_valid_q;
    assign bus.credit_vc    = credit_vc_q;
    assign bus.vc_count     = count;
    assign bus.err_overflow = err_ovf_q;
    assign bus.err_protocol = err_proto_q;
endmodule

// File: tb/tb_vc_input_unit.sv
// Scoreboard bench for vc_input_unit: queue-based reference model, directed cases then random traffic.
module tb_vc_input_unit;
    localparam int D_WIDTH = 32, NUM_VCS = 4, VC_DEPTH = 8, VID_BITS = 3, DEST_BITS = 4, CNT_BITS = 4;
`ifdef VC_SINGLE_FLIT_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vc_input_unit_if #(.D_WIDTH(D_WIDTH), .NUM_VCS(NUM_VCS), .VID_BITS(VID_BITS),
                       .DEST_BITS(DEST_BITS), .CNT_BITS(CNT_BITS)) bus ();

    vc_input_unit #(.D_WIDTH(D_WIDTH), .NUM_VCS(NUM_VCS), .VC_DEPTH(VC_DEPTH), .VID_BITS(VID_BITS),
                    .DEST_BITS(DEST_BITS), .CNT_BITS(CNT_BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0, n_err = 0, cyc = 0;
    bit mon_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a plain queue per VC plus the packet phase it is in.
    logic [D_WIDTH-1:0]   fifo [NUM_VCS][$];
    int                   phase [NUM_VCS];   // 0 wait route, 1 wait output VC, 2 wait switch
    logic [DEST_BITS-1:0] m_route [NUM_VCS];
    logic [VID_BITS-1:0]  m_ovid [NUM_VCS];
    bit                   m_eovf, m_eproto;
    int                   left [NUM_VCS];

    typedef struct packed {
        logic [D_WIDTH-1:0]   flit;
        logic [DEST_BITS-1:0] route;
        logic [VID_BITS-1:0]  ovid;
    } out_t;
    typedef struct {
        int vc;
        int due;
    } cred_t;
    out_t  exp_out [$];
    cred_t exp_cred [$];
    out_t  mo;
    cred_t mc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_head(input logic [1:0] t);
        return (t == 2'b11) || (SF && t == 2'b00);
    endfunction

    function automatic bit is_tail(input logic [1:0] t);
        return (t == 2'b01) || (SF && t == 2'b00);
    endfunction

    function automatic logic [3:0] low1(input logic [3:0] x);
        for (int i = 0; i < 4; i++) if (x[i]) return 4'(1 << i);
        return 4'b0;
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] vc,
                                       input logic [3:0] dest, input logic [22:0] pl);
        return {t, vc, dest, pl};
    endfunction

    // One clock cycle: check current status against the model, drive inputs,
    // predict the outputs of this cycle, then advance the model past the edge.
    task automatic step(input bit iv, input logic [31:0] fl, input logic [3:0] rg, input logic [3:0] rr,
                        input logic [3:0] vg, input logic [2:0] vo, input logic [3:0] sg);
        logic [3:0]  rq, vq, sq, bp, re, ve, se, pops;
        logic [15:0] ecnt;
        logic [1:0]  t;
        int          vid;
        rq = '0; vq = '0; sq = '0; bp = '0; ecnt = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            ecnt[v*4 +: 4] = 4'(fifo[v].size());
            if (fifo[v].size() > 0) begin
                t = fifo[v][0][31:30];
                if (phase[v] == 0) begin
                    if (is_head(t)) rq[v] = 1'b1;
                    else bp[v] = 1'b1;
                end else if (phase[v] == 1) vq[v] = 1'b1;
                else sq[v] = 1'b1;
            end
        end
        chk("req_vectors", 64'({bus.rc_req, bus.vc_req, bus.sa_req}), 64'({rq, vq, sq}));
        chk("vc_count", 64'(bus.vc_count), 64'(ecnt));
        chk("err_flags", 64'({bus.err_overflow, bus.err_protocol}), 64'({m_eovf, m_eproto}));

        bus.in_valid = iv; bus.in_flit = fl;
        bus.rc_gnt = rg; bus.rc_route = rr;
        bus.vc_gnt = vg; bus.vc_ovid = vo;
        bus.sa_gnt = sg;

        re = low1(rg & rq); ve = low1(vg & vq); se = low1(sg & sq);
        pops = se | bp;
        if (bp != 0) m_eproto = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (se[v]) begin
                exp_out.push_back(out_t'{flit: fifo[v][0], route: m_route[v], ovid: m_ovid[v]});
                exp_cred.push_back('{vc: v, due: cyc + 1});
                if (is_tail(fifo[v][0][31:30])) phase[v] = 0;
            end
            if (pops[v]) void'(fifo[v].pop_front());
            if (re[v]) begin phase[v] = 1; m_route[v] = rr; end
            if (ve[v]) begin phase[v] = 2; m_ovid[v] = vo; end
        end
        if (iv) begin
            vid = int'(fl[29:27]);
            t   = fl[31:30];
            if (vid >= NUM_VCS || (!SF && t == 2'b00)) m_eproto = 1'b1;
            else if (fifo[vid].size() == VC_DEPTH && !pops[vid]) m_eovf = 1'b1;
            else fifo[vid].push_back(fl);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_flit = '0; bus.rc_gnt = '0; bus.rc_route = '0;
        bus.vc_gnt = '0; bus.vc_ovid = '0; bus.sa_gnt = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            fifo[v].delete(); phase[v] = 0; m_route[v] = '0; m_ovid[v] = '0; left[v] = 0;
        end
        m_eovf = 1'b0; m_eproto = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(exp_out.size() != 0));
            if (exp_out.size() != 0) begin
                mo = exp_out.pop_front();
                if (bus.out_valid) chk("out_flit_route_ovid", 64'({bus.out_flit, bus.out_route, bus.out_ovid}), 64'(mo));
            end else chk("out_idle_zero", 64'({bus.out_flit, bus.out_route, bus.out_ovid}), 64'(0));
            if (bus.credit_valid) begin
                if (exp_cred.size() == 0) chk("credit_valid", 64'(bus.credit_valid), 64'(0));
                else begin
                    mc = exp_cred.pop_front();
                    chk("credit_vc", 64'(bus.credit_vc), 64'(mc.vc));
                    chk("credit_cycle", 64'(cyc), 64'(mc.due));
                end
            end else if (exp_cred.size() != 0 && exp_cred[0].due <= cyc) begin
                mc = exp_cred.pop_front();
                chk("credit_valid", 64'(bus.credit_valid), 64'(1));
            end
        end
    end

    initial begin
        logic [1:0] t;
        int vc, r, len;
        logic [3:0] rg, vg, sg;
        do_reset();
        chk("reset_credit", 64'({bus.credit_valid, bus.credit_vc}), 64'(0));
        chk("reset_reqs", 64'({bus.rc_req, bus.vc_req, bus.sa_req}), 64'(0));

        // 3-flit packet on VC2
        step(1, mk(2'b11, 2, 5, 23'h111), 0, 0, 0, 0, 0);
        step(1, mk(2'b10, 2, 0, 23'h222), 0, 0, 0, 0, 0);
        step(1, mk(2'b01, 2, 0, 23'h333), 4'b0100, 5, 0, 0, 0);
        step(0, '0, 0, 0, 4'b0100, 1, 0);
        repeat (3) step(0, '0, 0, 0, 0, 0, 4'b0100);
        idle(2);
        chk("vc2_route_done", 64'(bus.rc_req[2]), 64'(0));

        // Fill VC0, overflow, then write while popping
        do_reset();
        step(1, mk(2'b11, 0, 3, 23'h0), 0, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) step(1, mk(2'b10, 0, 0, 23'(i)), 0, 0, 0, 0, 0);
        step(1, mk(2'b10, 0, 0, 23'h99), 0, 0, 0, 0, 0);
        chk("vc0_full", 64'(bus.vc_count[3:0]), 64'(8));
        chk("overflow_set", 64'(bus.err_overflow), 64'(1));
        step(0, '0, 4'b0001, 3, 0, 0, 0);
        step(0, '0, 0, 0, 4'b0001, 2, 0);
        step(1, mk(2'b10, 0, 0, 23'haa), 0, 0, 0, 0, 4'b0001);
        chk("vc0_full_after_pop", 64'(bus.vc_count[3:0]), 64'(8));

        // Two VCs in SA_BID with a two-bit switch grant
        do_reset();
        step(1, mk(2'b11, 0, 1, 23'h10), 0, 0, 0, 0, 0);
        step(1, mk(2'b11, 1, 2, 23'h20), 0, 0, 0, 0, 0);
        step(1, mk(2'b01, 0, 0, 23'h11), 4'b0001, 1, 0, 0, 0);
        step(1, mk(2'b01, 1, 0, 23'h21), 4'b0010, 2, 0, 0, 0);
        step(0, '0, 0, 0, 4'b0001, 3, 0);
        step(0, '0, 0, 0, 4'b0010, 4, 0);
        step(0, '0, 0, 0, 0, 0, 4'b0011);
        chk("vc1_count_held", 64'(bus.vc_count[7:4]), 64'(2));

        // Stray body on VC3, then an out-of-range VC id
        do_reset();
        step(1, mk(2'b10, 3, 0, 23'h33), 0, 0, 0, 0, 0);
        idle(2);
        chk("vc3_no_rc_req", 64'(bus.rc_req[3]), 64'(0));
        chk("bad_head_proto", 64'(bus.err_protocol), 64'(1));
        do_reset();
        step(1, mk(2'b11, 6, 0, 23'h66), 0, 0, 0, 0, 0);
        idle(1);
        chk("bad_vid_counts", 64'(bus.vc_count), 64'(0));

        // Type 00 flit on VC1
        do_reset();
        step(1, mk(2'b00, 1, 7, 23'h77), 0, 0, 0, 0, 0);
        step(0, '0, 4'b0010, 7, 0, 0, 0);
        step(0, '0, 0, 0, 4'b0010, 5, 0);
        step(0, '0, 0, 0, 0, 0, 4'b0010);
        idle(2);

        // Reset in the middle of a packet
        step(1, mk(2'b11, 0, 9, 23'h1), 0, 0, 0, 0, 0);
        step(1, mk(2'b10, 0, 0, 23'h2), 4'b0001, 9, 0, 0, 0);
        step(1, mk(2'b10, 1, 0, 23'h3), 0, 0, 4'b0001, 2, 0);
        do_reset();
        chk("midreset_counts", 64'(bus.vc_count), 64'(0));
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            vc = $urandom_range(0, NUM_VCS - 1);
            r  = $urandom_range(0, 99);
            if (r < 3) begin
                t = 2'b11; vc = $urandom_range(4, 7);
            end else if (r < 5) begin
                t = 2'b00;
                if (SF) t = 2'b10;
            end else if (left[vc] == 0) begin
                len = $urandom_range(1, 4);
                if (len == 1 && SF) t = 2'b00;
                else begin
                    t = 2'b11; left[vc] = (len == 1) ? 1 : len - 1;
                end
            end else begin
                t = (left[vc] == 1) ? 2'b01 : 2'b10;
                left[vc]--;
            end
            rg = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
            vg = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
            sg = $urandom_range(0, 2) != 0 ? 4'($urandom) : 4'b0;
            step($urandom_range(0, 99) < 55, mk(t, 3'(vc), 4'($urandom), 23'($urandom)),
                 rg, 4'($urandom), vg, 3'($urandom), sg);
        end
        for (int i = 0; i < 100; i++) step(0, '0, 4'hf, 4'($urandom), 4'hf, 3'($urandom), 4'hf);
        idle(3);
        chk("scoreboard_out_drained", 64'(exp_out.size()), 64'(0));
        chk("scoreboard_credit_drained", 64'(exp_cred.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vc_input_unit.md
Name: vc_input_unit

Overview:
Multi-VC router input port: NUM_VCS virtual-channel FIFOs, each with its own route-compute / VC-allocate / switch-allocate bid state machine.
Demultiplexes incoming flits by their VC id field, presents one request vector per allocation stage, and muxes the switch-granted VC's front flit to the crossbar.
Returns one credit per departing flit to the upstream router.
Generalises the single-VC input buffer to N VCs with credit return, a packed status output and error flags.

Parameters:
D_WIDTH, 32, flit width in bits
NUM_VCS, 4, number of virtual channels (2..16)
VC_DEPTH, 8, flits per VC FIFO (power of two, >=2)
VID_BITS, 2, VC id field width (>= clog2(NUM_VCS))
DEST_BITS, 4, route / destination field width
CNT_BITS, 4, per-VC occupancy width (clog2(VC_DEPTH+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  in_flit valid this cycle
in_flit  in  D_WIDTH  [D-1:D-2] type (11 head, 10 body, 01 tail, 00 head+tail); [D-3 -: VID_BITS] VC id; next DEST_BITS dest (head only)
rc_req  out  NUM_VCS  per-VC route-compute request
rc_gnt  in  NUM_VCS  RC grant, one-hot or zero
rc_route  in  DEST_BITS  route for the RC-granted VC
vc_req  out  NUM_VCS  per-VC output-VC request
vc_gnt  in  NUM_VCS  VC-allocation grant, one-hot or zero
vc_ovid  in  VID_BITS  output VC for the VA-granted VC
sa_req  out  NUM_VCS  per-VC switch request
sa_gnt  in  NUM_VCS  switch grant, one-hot or zero
out_valid  out  1  out_flit valid (combinational, equals |sa_gnt & sa_req)
out_flit  out  D_WIDTH  front flit of the SA-granted VC
out_route  out  DEST_BITS  latched route of the granted VC
out_ovid  out  VID_BITS  latched output VC of the granted VC
credit_valid  out  1  registered credit pulse to upstream
credit_vc  out  VID_BITS  VC of the returned credit
vc_count  out  NUM_VCS*CNT_BITS  packed per-VC occupancy, VC0 in the LSBs
err_overflow  out  1  sticky: write to a full VC
err_protocol  out  1  sticky: bad type or bad VC id

Behaviour:
- Reset values: all FIFOs empty; every VC in RC_BID; route and ovid registers 0; credit_valid 0; credit_vc 0; error flags 0; all req outputs 0.
- Write path:
  - in_valid with VC id < NUM_VCS writes that VC's FIFO; visible at the front the next cycle.
  - VC id >= NUM_VCS: flit dropped, err_protocol set.
  - Write to a full VC: accepted only if the same VC pops in the same cycle; otherwise dropped and err_overflow set.
- Per-VC state machine, states RC_BID -> VC_BID -> SA_BID:
  - rc_req[v] = !empty[v] && state==RC_BID; vc_req and sa_req are formed the same way for their states.
  - RC_BID: front flit must be a head. A non-head front flit is popped, err_protocol set, no credit returned, VC stays in RC_BID.
  - RC_BID: rc_gnt[v] latches rc_route into route[v]; next state VC_BID.
  - VC_BID: vc_gnt[v] latches vc_ovid into ovid[v]; next state SA_BID.
  - SA_BID: sa_gnt[v] && sa_req[v] pops the front flit. If that flit is tail or head+tail, next state is RC_BID; otherwise the VC stays in SA_BID.
  - Grant bits arriving without the matching req are ignored.
- Grant vectors that are not one-hot: the lowest set bit is honoured, other bits ignored.
- Output path: out_flit, out_route and out_ovid are a zero-latency mux on the honoured sa_gnt bit. Outputs are 0 when out_valid=0.
- Credits: each SA pop produces credit_valid=1 with credit_vc=v one cycle later. Each credit is a single-cycle pulse; at most one per cycle.
- Occupancy: vc_count[v] is the registered occupancy, updated the cycle after the write or pop. A simultaneous write and pop on one VC leaves the count unchanged.
- Pointers: FIFO pointers wrap modulo VC_DEPTH.
- Reset mid-packet: flushes all FIFOs and states; no credits are issued for flushed flits.

Optional Feature:
VC_SINGLE_FLIT_EN
- Defined: type 00 is head+tail. It bids RC, VC and SA like a head, and its departure returns the VC to RC_BID.
- Undefined: type 00 is illegal. It is dropped on write (never stored) and err_protocol is set.

Test Plan:
- 3-flit packet (head dest=5, body, tail) on VC2; rc_gnt=0100 with rc_route=5, then vc_gnt=0100 with vc_ovid=1, then sa_gnt=0100 for 3 cycles -> out_route=5, out_ovid=1, three flits out in order, credit_valid on 3 consecutive cycles with credit_vc=2, VC2 back in RC_BID.
- Fill VC0 with 8 flits, then send a 9th -> vc_count[0]=8, err_overflow=1. Repeat the 9th write in the same cycle as an SA pop on VC0 -> accepted, count stays 8.
- Packets on VC0 and VC1 both in SA_BID with sa_gnt=0011 -> only the VC0 flit is output and popped; VC1 count unchanged.
- Body flit arrives first on VC3 -> it is popped in RC_BID, err_protocol=1, no credit pulse, rc_req[3]=0 afterwards.
- Flit with VC id 6 and NUM_VCS=4 -> dropped, err_protocol=1, all counts unchanged.
- Type 00 flit on VC1: with the macro defined -> RC/VC/SA sequence, one credit, VC1 back in RC_BID. Without the macro -> dropped, err_protocol=1. Separately, assert rst mid-packet -> all counts 0, all VCs in RC_BID, no credits.
